// File: rtl/softex_pkg.sv
// Shared types and helpers for the SoftEx lane split/merge engine.
// Latency: none (types and a pure mapping function only).
// Backpressure: not applicable.
// Contents: lane_cfg_t (runtime lane configuration) and elem_map(), which maps a
// wide-beat element index to the {phase, physical lane, lane slot} it travels on.
package softex_pkg;

  // Wide enough for any realistic physical lane count (up to 2^15 lanes).
  localparam int LANES_LOG2_W = 4;

  typedef struct packed {
    logic [LANES_LOG2_W-1:0] lanes_log2;
  } lane_cfg_t;

  typedef struct packed {
    logic [15:0] phase;
    logic [15:0] lane;
    logic [15:0] slot;
  } elem_map_t;

  // Element e lives on virtual lane v = e mod NUM_LANES in slot e div NUM_LANES.
  // Virtual lanes are folded onto the A = 1<<lanes_log2 active lanes over phases.
  function automatic elem_map_t elem_map(input int e, input int num_lanes,
                                         input logic [LANES_LOG2_W-1:0] lanes_log2);
    elem_map_t m;
    int        v;
    v       = e % num_lanes;
    m.slot  = 16'(e / num_lanes);
    m.phase = 16'(v >> lanes_log2);
    m.lane  = 16'(v & ((1 << lanes_log2) - 1));
    return m;
  endfunction

endpackage

// File: rtl/softex_lane_phase_tracker.sv
// Phase counter plus per-lane done bits with completion detect, shared by split and merge.
// Latency: completion is combinational on hs_i; phase/done update at the next clock edge.
// Backpressure: none of its own; it only observes the handshakes its owner reports.
// Ports: clk_i, rst_i/clear_i (both synchronous, same effect here), lanes_log2_i,
//        active_i (lane < A mask), hs_i (lane handshakes this cycle),
//        phase_o, done_o (lanes finished in the current phase), wrap_o (last phase completes now).
module softex_lane_phase_tracker
  import softex_pkg::*;
#(
  parameter  int NUM_LANES  = 4,
  localparam int LOG2_LANES = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0,
  localparam int PH_W       = (LOG2_LANES > 0) ? LOG2_LANES : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [LANES_LOG2_W-1:0] lanes_log2_i,
  input  logic [NUM_LANES-1:0]    active_i,
  input  logic [NUM_LANES-1:0]    hs_i,
  output logic [PH_W-1:0]         phase_o,
  output logic [NUM_LANES-1:0]    done_o,
  output logic                    wrap_o
);

  logic [PH_W-1:0]      phase_q, phase_d;
  logic [NUM_LANES-1:0] done_q, done_d;
  logic                 complete;
  logic                 last_phase;

  // Handshakes in the current cycle count toward completion; inactive lanes are
  // treated as already done.
  assign complete   = &(done_q | hs_i | ~active_i);
  assign last_phase = (phase_q == PH_W'((NUM_LANES >> lanes_log2_i) - 1));
  assign wrap_o     = complete & last_phase;
  assign phase_o    = phase_q;
  assign done_o     = done_q;

  always_comb begin
    phase_d = phase_q;
    done_d  = (done_q | hs_i) & active_i;
    if (complete) begin
      done_d  = '0;
      phase_d = last_phase ? '0 : phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      phase_q <= '0;
      done_q  <= '0;
    end else begin
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/softex_lane_splitmerge.sv
// Lane split/merge: wide beats are spread element-interleaved over A active lanes
// in P = NUM_LANES/A phases, and lane results are reassembled with the inverse map.
// Latency: accepted beat -> lane valid next cycle; last lane result -> out_valid_o next cycle.
// Backpressure: lanes complete independently; in_ready_o waits for the last phase to finish;
//   while a merged beat waits on out_ready_i the lanes stall, except that next-beat phase-0
//   data is taken in the same cycle the output drains.
// Ports: clk_i, rst_i, clear_i (also loads cfg_lanes_log2_i), wide in/out streams,
//        per-lane out/in streams, split_busy_o / merge_busy_o.
module softex_lane_splitmerge
  import softex_pkg::*;
#(
  parameter  int DATA_WIDTH    = 256,
  parameter  int ELEMENT_WIDTH = 16,
  parameter  int NUM_LANES     = 4,
  localparam int LANE_WIDTH    = DATA_WIDTH / NUM_LANES,
  localparam int EPB           = DATA_WIDTH / ELEMENT_WIDTH,
  localparam int LOG2_LANES    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0,
  localparam int CFG_W         = (LOG2_LANES > 0) ? $clog2(LOG2_LANES + 1) : 1,
  localparam int PH_W          = (LOG2_LANES > 0) ? LOG2_LANES : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic [CFG_W-1:0]                cfg_lanes_log2_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [DATA_WIDTH-1:0]           in_data_i,
  output logic [NUM_LANES-1:0]            lane_out_valid_o,
  input  logic [NUM_LANES-1:0]            lane_out_ready_i,
  output logic [NUM_LANES*LANE_WIDTH-1:0] lane_out_data_o,
  input  logic [NUM_LANES-1:0]            lane_in_valid_i,
  output logic [NUM_LANES-1:0]            lane_in_ready_o,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_in_data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic                            split_busy_o,
  output logic                            merge_busy_o
);

  logic flush;
  assign flush = rst_i | clear_i;

  // ---------------------------------------------------------------- configuration
  lane_cfg_t lanes_cfg_q, lanes_cfg_d;

  always_comb begin
    lanes_cfg_d = lanes_cfg_q;
    if (clear_i) begin
      lanes_cfg_d.lanes_log2 = (int'(cfg_lanes_log2_i) > LOG2_LANES)
                             ? LANES_LOG2_W'(LOG2_LANES) : LANES_LOG2_W'(cfg_lanes_log2_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lanes_cfg_q.lanes_log2 <= LANES_LOG2_W'(LOG2_LANES);
    else       lanes_cfg_q            <= lanes_cfg_d;
  end

  // lane l is active iff l < A, i.e. l >> log2(A) == 0
  logic [NUM_LANES-1:0] active_mask;
  always_comb begin
    active_mask = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      active_mask[l] = ((l >> lanes_cfg_q.lanes_log2) == 0);
    end
  end

  // ---------------------------------------------------------------- split half
  logic [DATA_WIDTH-1:0] beat_q, beat_d;
  logic                  beat_valid_q, beat_valid_d;
  logic [NUM_LANES-1:0]  split_hs, split_sent;
  logic [PH_W-1:0]       split_phase;
  logic                  split_wrap;
  logic                  in_accept;

  softex_lane_phase_tracker #(.NUM_LANES(NUM_LANES)) u_split_trk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .lanes_log2_i (lanes_cfg_q.lanes_log2),
    .active_i     (active_mask),
    .hs_i         (split_hs),
    .phase_o      (split_phase),
    .done_o       (split_sent),
    .wrap_o       (split_wrap)
  );

  assign lane_out_valid_o = {NUM_LANES{beat_valid_q}} & active_mask & ~split_sent;
  assign split_hs         = lane_out_valid_o & lane_out_ready_i;
  // Ready also while the final phase drains, so back-to-back beats have no bubble.
  assign in_ready_o       = ~flush & (~beat_valid_q | split_wrap);
  assign in_accept        = in_valid_i & in_ready_o;

  always_comb begin
    beat_d       = beat_q;
    beat_valid_d = beat_valid_q;
    if (split_wrap) beat_valid_d = 1'b0;
    if (in_accept) begin
      beat_d       = in_data_i;
      beat_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      beat_q       <= '0;
      beat_valid_q <= 1'b0;
    end else begin
      beat_q       <= beat_d;
      beat_valid_q <= beat_valid_d;
    end
  end

  // Elements of the current phase are steered to their lane/slot; everything else,
  // including inactive lanes, reads as zero.
  always_comb begin
    elem_map_t m;
    m               = '0;
    lane_out_data_o = '0;
    for (int e = 0; e < EPB; e++) begin
      m = elem_map(e, NUM_LANES, lanes_cfg_q.lanes_log2);
      if (beat_valid_q && (m.phase == 16'(split_phase))) begin
        lane_out_data_o[int'(m.lane)*LANE_WIDTH + int'(m.slot)*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
          beat_q[e*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end
    end
  end

  assign split_busy_o = beat_valid_q;

  // ---------------------------------------------------------------- merge half
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  full_q, full_d;
  logic [NUM_LANES-1:0]  merge_hs, merge_got;
  logic [PH_W-1:0]       merge_phase;
  logic                  merge_wrap;
  logic                  merge_drain;

  softex_lane_phase_tracker #(.NUM_LANES(NUM_LANES)) u_merge_trk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .lanes_log2_i (lanes_cfg_q.lanes_log2),
    .active_i     (active_mask),
    .hs_i         (merge_hs),
    .phase_o      (merge_phase),
    .done_o       (merge_got),
    .wrap_o       (merge_wrap)
  );

  // A full accumulator only admits phase-0 data of the next beat, and only in the
  // cycle it drains; phase-0 elements are rewritten after the old value leaves.
  assign merge_drain = full_q & out_ready_i & (merge_phase == '0);

  always_comb begin
    lane_in_ready_o = '0;
    if (!flush) begin
      lane_in_ready_o = active_mask & (full_q ? {NUM_LANES{merge_drain}} : ~merge_got);
    end
  end

  assign merge_hs = lane_in_valid_i & lane_in_ready_o;

  always_comb begin
    elem_map_t m;
    m     = '0;
    acc_d = acc_q;
    for (int e = 0; e < EPB; e++) begin
      m = elem_map(e, NUM_LANES, lanes_cfg_q.lanes_log2);
      if ((m.phase == 16'(merge_phase)) && merge_hs[int'(m.lane)]) begin
        acc_d[e*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
          lane_in_data_i[int'(m.lane)*LANE_WIDTH + int'(m.slot)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end
    end
  end

  assign full_d = merge_wrap | (full_q & ~out_ready_i);

  always_ff @(posedge clk_i) begin
    if (flush) begin
      acc_q  <= '0;
      full_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      full_q <= full_d;
    end
  end

  assign out_valid_o  = full_q;
  assign out_data_o   = acc_q;
  assign merge_busy_o = full_q | (|merge_got) | (merge_phase != '0);

endmodule
